// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the odd-parity of the inputs; carry is their majority.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell adds two WIDTH-bit operands LSB
// first, one bit per clock, behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one bit pair per clock through the full adder
// DONE  | one-cycle done pulse; a start here is accepted back-to-back
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 partial bits need storing: the newest bit
    // arrives from the adder and the oldest drops out on the final edge.
    logic [WIDTH-2:0] p_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] p_next;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign p_next   = {fa_sum, p_sh};
    assign last_bit = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state decode plus Moore handshake outputs.
    always_comb begin
        nxt    = state;
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept = 1'b1;
                    nxt    = RUN;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Operand load on accept, bit-serial shift during RUN, result capture
    // on the final bit so sum/cout keep the previous result until then.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            p_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            p_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            p_sh  <= p_next[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= p_next;
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for handshake,
// ripple, ignore-in-RUN, back-to-back and reset cases, plus a 4-bit
// instance swept over every operand/carry combination.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one 8-bit add, then check busy length, done timing and result.
    task automatic add8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        int nbusy;
        a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        nbusy = 0;
        while (!done8 && n < 20) begin
            if (busy8) nbusy++;
            tick();
            n++;
        end
        chk({tag, "_lat"},  32'(n), 32'd8);
        chk({tag, "_busy"}, 32'(nbusy), 32'd8);
        chk({tag, "_bd"},   32'(busy8), 32'd0);
        chk({tag, "_sum"},  32'(sum8), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout8), 32'(exp_cout));
    endtask

    initial begin
        logic [7:0] prev_sum;
        logic [7:0] ops_a [4];
        logic [7:0] ops_b [4];
        logic       ops_c [4];
        logic [8:0] exp9;
        logic [4:0] exp5;
        int n;
        int ndone;
        int lat_bad;
        int res_bad;

        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        reset = 1'b0;
        tick();

        // Basic add and full carry ripple cases.
        add8("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        tick();
        chk("t1_idle_done", 32'(done8), 32'd0);
        add8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        add8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        tick();

        // Start/operand changes during RUN are ignored; previous result holds.
        prev_sum = 8'hFF;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
            end
            if (i == 3) start8 = 1'b0;
            if (i == 4) begin
                chk("t3_hold_sum",  32'(sum8),  32'(prev_sum));
                chk("t3_hold_cout", 32'(cout8), 32'd1);
                chk("t3_busy_mid",  32'(busy8), 32'd1);
            end
            if (i == 5) cin8 = 1'b0;
            if (done8) ndone++;
            tick();
        end
        chk("t3_ndone", 32'(ndone), 32'd1);
        chk("t3_sum",   32'(sum8),  32'h30);
        chk("t3_cout",  32'(cout8), 32'd0);

        // Back-to-back: start held high, new operands loaded in each DONE cycle.
        ops_a[0] = 8'h01; ops_b[0] = 8'h02; ops_c[0] = 1'b0;
        ops_a[1] = 8'h80; ops_b[1] = 8'h80; ops_c[1] = 1'b1;
        ops_a[2] = 8'hC3; ops_b[2] = 8'h5A; ops_c[2] = 1'b1;
        ops_a[3] = 8'h00; ops_b[3] = 8'h00; ops_c[3] = 1'b0;
        a8 = ops_a[0]; b8 = ops_b[0]; cin8 = ops_c[0]; start8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!done8 && n < 20);
            exp9 = {1'b0, ops_a[k]} + {1'b0, ops_b[k]} + {8'd0, ops_c[k]};
            chk($sformatf("t4_period%0d", k), 32'(n), 32'd9);
            chk($sformatf("t4_res%0d", k), 32'({cout8, sum8}), 32'(exp9));
            if (k == 2) start8 = 1'b0;
            a8 = ops_a[k+1]; b8 = ops_b[k+1]; cin8 = ops_c[k+1];
        end
        tick();
        chk("t4_idle_busy", 32'(busy8), 32'd0);

        // Reset in the middle of RUN discards the operation.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", 32'(busy8), 32'd0);
        chk("t5_done", 32'(done8), 32'd0);
        chk("t5_sum",  32'(sum8),  32'd0);
        chk("t5_cout", 32'(cout8), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) ndone++;
            tick();
        end
        chk("t5_quiet", 32'(ndone), 32'd0);
        add8("t5_after", 8'h9C, 8'h64, 1'b1, 8'h01, 1'b1);
        tick();

        // WIDTH=4 exhaustive sweep.
        lat_bad = 0;
        res_bad = 0;
        for (int c = 0; c < 512; c++) begin
            a4 = 4'(c >> 5); b4 = 4'(c >> 1); cin4 = c[0];
            exp5 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            n = 0;
            while (!done4 && n < 12) begin
                tick();
                n++;
            end
            if (n != 4) begin
                lat_bad++;
                chk($sformatf("t6_lat_%0d", c), 32'(n), 32'd4);
            end
            if ({cout4, sum4} !== exp5) begin
                res_bad++;
                chk($sformatf("t6_res_%0d", c), 32'({cout4, sum4}), 32'(exp5));
            end
            tick();
        end
        chk("t6_lat_all", 32'(lat_bad), 32'd0);
        chk("t6_res_all", 32'(res_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
